fir_out_packer: RTL

Output stage placed directly after the dual-channel decimating FIR. It consumes the FIR's 32-bit signed results, which carry no backpressure and alternate channel A then channel B. It applies round-half-up and an arithmetic right shift, then saturates each result to 16 bits. It packs each A/B pair into one 32-bit word, buffers the words in a small FIFO and presents them as an AXI-stream master with backpressure, framing (`m_tlast`) and a sticky overflow flag.

---
 rtl/fir_pkg.sv | 56 +++++
 rtl/fir_sync_fifo.sv | 78 +++++++
 rtl/fir_out_packer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, types and the round/saturate helpers for the
// FIR output stage. The helpers operate at the package default widths.
package fir_pkg;

  localparam int FIR_IN_W  = 32;
  localparam int FIR_OUT_W = 16;

  // One packed output word: {B, A}.
  typedef logic [2*FIR_OUT_W-1:0] packed_word_t;

  // One extra bit of headroom so the rounding bias can never wrap.
  typedef logic signed [FIR_IN_W:0] wide_t;

  localparam wide_t WIDE_ONE = wide_t'(1);
  localparam wide_t SAT_MAX  =
    $signed({{(FIR_IN_W-FIR_OUT_W+2){1'b0}}, {(FIR_OUT_W-1){1'b1}}});
  localparam wide_t SAT_MIN  =
    $signed({{(FIR_IN_W-FIR_OUT_W+2){1'b1}}, {(FIR_OUT_W-1){1'b0}}});

  localparam logic [FIR_OUT_W-1:0] OUT_MAX = {1'b0, {(FIR_OUT_W-1){1'b1}}};
  localparam logic [FIR_OUT_W-1:0] OUT_MIN = {1'b1, {(FIR_OUT_W-1){1'b0}}};

  // Round half up, then arithmetic shift right, at IN_W+1 bits.
  function automatic wide_t round_shift(input logic signed [FIR_IN_W-1:0] in,
                                        input int unsigned shift);
    wide_t ext;
    ext = $signed({in[FIR_IN_W-1], in});
    if (shift > 0) begin
      ext = (ext + (WIDE_ONE <<< (shift - 1))) >>> shift;
    end
    return ext;
  endfunction

  // True when the rounded value falls outside the signed OUT_W range.
  function automatic logic sat_hit(input logic signed [FIR_IN_W-1:0] in,
                                   input int unsigned shift);
    wide_t r;
    r = round_shift(in, shift);
    return (r > SAT_MAX) || (r < SAT_MIN);
  endfunction

  // Rounded, shifted and saturated sample.
  function automatic logic [FIR_OUT_W-1:0] sat_round(
      input logic signed [FIR_IN_W-1:0] in, input int unsigned shift);
    wide_t r;
    r = round_shift(in, shift);
    if (r > SAT_MAX) begin
      return OUT_MAX;
    end else if (r < SAT_MIN) begin
      return OUT_MIN;
    end else begin
      return r[FIR_OUT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// fir_sync_fifo: single-clock FIFO with count-based full/empty and a
// registered read-data port that always shows the head entry. A push while
// full is accepted when a pop happens in the same cycle.
module fir_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign valid = (count != '0);

  // Accept/advance decisions for this cycle.
  always_comb begin
    do_pop     = rd_en && valid;
    do_push    = wr_en && (!full || do_pop);
    rd_ptr_nxt = do_pop ? rd_ptr + 1'b1 : rd_ptr;
  end

  // Storage array write port.
  // NOTE: the array has no reset; only pointers and count define contents,
  // so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and the registered head word.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // The new head is the word being written when that slot becomes head.
      if (do_push || do_pop) begin
        if (do_push && (wr_ptr == rd_ptr_nxt)) begin
          rd_data <= wr_data;
        end else begin
          rd_data <= mem[rd_ptr_nxt];
        end
      end
    end
  end

endmodule

// File: rtl/fir_out_packer.sv
// fir_out_packer: rounds, shifts and saturates the dual-channel FIR results,
// packs each A/B pair into one word and streams words out through a FIFO
// with framing and a sticky overflow flag.
// Optional feature: define FIR_OUT_SAT_CNT_EN to add the saturation counter
// and its sat_count port.
// IN_W/OUT_W must match the fir_pkg defaults used by the helper functions.
module fir_out_packer
  import fir_pkg::*;
#(
  parameter int          IN_W      = FIR_IN_W,
  parameter int          OUT_W     = FIR_OUT_W,
  parameter int unsigned SHIFT     = 0,
  parameter int          DEPTH     = 16,
  parameter int          FRAME_LEN = 64
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               s_tvalid,
  input  logic [IN_W-1:0]    s_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [2*OUT_W-1:0] m_tdata,
  output logic               m_tlast,
`ifdef FIR_OUT_SAT_CNT_EN
  output logic [15:0]        sat_count,
`endif
  output logic               overflow
);

  localparam int FCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic {CH_A = 1'b0, CH_B = 1'b1} ch_t;

  ch_t              ch;
  ch_t              ch_nxt;
  logic [OUT_W-1:0] lane_a;
  logic [OUT_W-1:0] sample;
  logic             sample_sat;
  logic             push;
  logic             pop;
  logic             fifo_full;
  packed_word_t     push_word;
  logic [FCNT_W-1:0] fcnt;

  // Per-sample rounding, saturation and channel bookkeeping.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ch_nxt     = ch;
    sample     = sat_round(s_tdata, SHIFT);
    sample_sat = sat_hit(s_tdata, SHIFT);
    push       = 1'b0;
    push_word  = {sample, lane_a};
    if (s_tvalid) begin
      ch_nxt = (ch == CH_A) ? CH_B : CH_A;
      push   = (ch == CH_B);
    end
  end

  assign pop     = m_tvalid && m_tready;
  assign m_tlast = m_tvalid && (fcnt == FCNT_W'(FRAME_LEN - 1));

  // Channel toggle register: first sample after reset is A.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ch <= CH_A;
    end else begin
      ch <= ch_nxt;
    end
  end

  // Hold the A sample until its B partner arrives.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lane_a <= '0;
    end else if (s_tvalid && (ch == CH_A)) begin
      lane_a <= sample;
    end
  end

  // Sticky flag: a completed pair was dropped because the FIFO stayed full.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !m_tready) begin
      overflow <= 1'b1;
    end
  end

  // Frame position counts delivered words only.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fcnt <= '0;
    end else if (pop) begin
      if (fcnt == FCNT_W'(FRAME_LEN - 1)) begin
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

`ifdef FIR_OUT_SAT_CNT_EN
  // Saturation event counter, clamps at all-ones.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sat_count <= '0;
    end else if (s_tvalid && sample_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = sample_sat;
`endif

  fir_sync_fifo #(
    .WIDTH (2*OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (push),
    .wr_data (push_word),
    .full    (fifo_full),
    .rd_en   (m_tready),
    .rd_data (m_tdata),
    .valid   (m_tvalid)
  );

endmodule
